divide_by_n_seq: RTL and testbench
==================================

Name: divide_by_n_seq

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse operation of the team's shift-based multiply block.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, producing one quotient bit per clock.
- Uses a start/busy/done handshake and sits in the arithmetic datapath alongside the multiply blocks.
- Flags divide-by-zero instead of hanging or producing undefined results.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder; legal range 2..16.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  WIDTH  numerator; captured on an accepted start.
- divisor  input  WIDTH  denominator; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  result floor(dividend/divisor).
- remainder  output  WIDTH  result dividend mod divisor.
- div_by_zero  output  1  high with done when the captured divisor was 0; held with the results.

Behaviour:
- Reset: rst_n low at a clock edge forces state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset wins over every other event, including mid-RUN; a partial result is discarded.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: single cycle, done=1.
- IDLE or DONE with start=1:
  - Capture dividend and divisor.
  - Clear the partial remainder (WIDTH+1 bits) and set counter=WIDTH.
  - If divisor≠0, go to RUN.
  - If divisor=0, go to DONE directly.
- start=0: IDLE stays IDLE; DONE returns to IDLE.
- RUN, one step per cycle:
  - Form shifted = {prem[WIDTH-1:0], dq[WIDTH-1]} and shift dq left by 1.
  - If shifted ≥ {1'b0, divisor}: prem = shifted − divisor, dq[0]=1; else prem = shifted, dq[0]=0.
  - Decrement counter; when counter reaches 1 during a step, the next state is DONE.
- Latency:
  - Nonzero divisor: the start edge is at cycle 0; RUN occupies cycles 1..WIDTH; done is high in cycle WIDTH+1.
  - Divide-by-zero: done is high in cycle 1.
- Entering DONE:
  - quotient=dq and remainder=prem[WIDTH-1:0], div_by_zero=0.
  - On the zero-divisor path instead: quotient=all ones, remainder=captured dividend, div_by_zero=1.
- Output hold: quotient, remainder and div_by_zero hold until the next accepted start. On acceptance they are not cleared; they keep their old values until the new DONE.
- start during RUN is ignored; input changes during RUN have no effect.
- start high in the DONE cycle is accepted (back-to-back operation) and busy rises on the next cycle.
- busy=1 exactly in RUN cycles; done=1 exactly in DONE cycles; the two are never high together.
- Invariant on done: quotient*divisor + remainder == dividend, and remainder < divisor (nonzero divisor).

Decomposition:
- Shared arithmetic package holds:
  - state encoding typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - divide-by-zero quotient constant (all ones) as a WIDTH-parameterized function;
  - counter width as clog2(WIDTH+1).
- One natural sub-module, div_step: a purely combinational single restoring iteration (inputs prem, dq msb, divisor; outputs next prem, quotient bit).
- Top-level divide_by_n_seq owns the FSM, counter and registers.

Test Plan:
- Reset then dividend=13, divisor=4, start pulse -> busy high cycles 1–4, done in cycle 5 with quotient=3, remainder=1, div_by_zero=0.
- dividend=15, divisor=1, then dividend=3, divisor=9 -> 15/0, then 0/3; outputs hold between runs until the next start.
- dividend=7, divisor=0 -> done in cycle 1, quotient=4'b1111, remainder=7, div_by_zero=1, busy never high.
- 12/5 started, start re-pulsed with 9/3 during cycle 2 of RUN -> ignored; result 2/2. Then start held high in the DONE cycle with 9/3 -> accepted; next done gives 3/0.
- rst_n low in cycle 2 of a 14/3 run -> next cycle: IDLE, all outputs 0, no done pulse; a subsequent 14/3 gives 4/2.
- Exhaustive sweep of all 256 operand pairs (WIDTH=4) -> quotient and remainder match the reference / and %; div_by_zero exactly when divisor=0; done latency always 5 (nonzero divisor) or 1 (zero divisor).

Source files
------------

// File: rtl/divide_by_n_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state codes,
// counter sizing and the divide-by-zero quotient pattern.
package divide_by_n_seq_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // All-ones quotient reported when the divisor is zero, right-aligned to w bits.
    function automatic logic [MAX_WIDTH-1:0] dbz_quotient(input int unsigned w);
        logic [MAX_WIDTH:0] ones;
        ones = (17'(1) << w) - 17'(1);
        return MAX_WIDTH'(ones);
    endfunction

endpackage

// File: rtl/divide_by_n_seq_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it does not underflow.
module divide_by_n_seq_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   i_prem,
    input  logic             i_dq_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_prem_c,
    output logic             o_q_bit_c
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_div_ext;
    logic             w_ge;

    // The partial remainder always stays below the divisor, so its MSB is zero
    // and the wider shift is identical to shifting only the low WIDTH bits.
    assign w_shift   = {i_prem, i_dq_msb};
    assign w_div_ext = {2'b00, i_divisor};
    assign w_ge      = (w_shift >= w_div_ext);

    assign o_q_bit_c = w_ge;
    assign o_prem_c  = w_ge ? (WIDTH+1)'(w_shift - w_div_ext) : (WIDTH+1)'(w_shift);

endmodule

// File: rtl/divide_by_n_seq.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake;
// one quotient bit per clock, divide-by-zero flagged in a single cycle.
module divide_by_n_seq
    import divide_by_n_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned      CNT_W = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(dbz_quotient(WIDTH));

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_prem;
    logic [WIDTH-1:0]   r_dq;
    logic [WIDTH-1:0]   r_divisor;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic [WIDTH:0]     w_prem_nxt;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_dq_nxt;

    divide_by_n_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_prem    (r_prem),
        .i_dq_msb  (r_dq[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_prem_c  (w_prem_nxt),
        .o_q_bit_c (w_q_bit)
    );

    assign w_dq_nxt = {r_dq[WIDTH-2:0], w_q_bit};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; start is only honoured in IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; results hold until the next DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_prem      <= '0;
            r_dq        <= '0;
            r_divisor   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_RUN);
            r_done <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_dq      <= dividend;
                r_divisor <= divisor;
                r_prem    <= '0;
                r_cnt     <= CNT_W'(WIDTH);
                if (divisor == '0) begin
                    r_quotient  <= DBZ_Q;
                    r_remainder <= dividend;
                    r_dbz       <= 1'b1;
                end
            end else if (r_state == ST_RUN) begin
                r_prem <= w_prem_nxt;
                r_dq   <= w_dq_nxt;
                r_cnt  <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_quotient  <= w_dq_nxt;
                    r_remainder <= w_prem_nxt[WIDTH-1:0];
                    r_dbz       <= 1'b0;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divide_by_n_seq.sv
// Directed plus randomized bench for divide_by_n_seq against an arithmetic
// reference (/ and %), checking latency, handshake and result hold.
module tb_divide_by_n_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp;
    int n_err;

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic         prev_dbz;

    divide_by_n_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an operation for one edge; returns at the negedge of cycle 1.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        if (b != 0) begin
            chk({tag, ".hold_q"}, 32'(quotient), 32'(prev_q));
            chk({tag, ".hold_r"}, 32'(remainder), 32'(prev_r));
            chk({tag, ".hold_dbz"}, 32'(div_by_zero), 32'(prev_dbz));
        end
    endtask

    // Waits for done starting in cycle k0 and checks everything against / and %.
    task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int k0, input string tag);
        int k;
        int nb;
        bit seen;
        int exp_lat;
        int exp_nb;
        int exp_q;
        int exp_r;
        k  = k0;
        nb = 0;
        seen = 1'b0;
        exp_lat = (b != 0) ? W + 1 : 1;
        exp_nb  = (b != 0) ? W - (k0 - 1) : 0;
        exp_q   = (b != 0) ? int'(a) / int'(b) : (1 << W) - 1;
        exp_r   = (b != 0) ? int'(a) % int'(b) : int'(a);
        while (k <= 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            step();
            k++;
        end
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, ".latency"}, 32'(k), 32'(exp_lat));
            chk({tag, ".busy_cycles"}, 32'(nb), 32'(exp_nb));
            chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
            chk({tag, ".quotient"}, 32'(quotient), 32'(exp_q));
            chk({tag, ".remainder"}, 32'(remainder), 32'(exp_r));
            chk({tag, ".dbz"}, 32'(div_by_zero), 32'(b == 0));
            if (b != 0) begin
                chk({tag, ".invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            end
        end
        prev_q   = W'(exp_q);
        prev_r   = W'(exp_r);
        prev_dbz = (b == 0);
    endtask

    task automatic idle_after(input string tag);
        step();
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        launch(a, b, tag);
        wait_done(a, b, 1, tag);
        idle_after(tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;

        @(negedge clk);
        step();
        step();
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.q", 32'(quotient), 32'd0);
        chk("reset.r", 32'(remainder), 32'd0);
        chk("reset.dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        step();

        full_op(4'd13, 4'd4, "d13_4");
        full_op(4'd15, 4'd1, "d15_1");
        step();
        step();
        chk("hold_idle.q", 32'(quotient), 32'd15);
        chk("hold_idle.r", 32'(remainder), 32'd0);
        full_op(4'd3, 4'd9, "d3_9");
        full_op(4'd7, 4'd0, "d7_0");
        full_op(4'd0, 4'd1, "d0_1");
        full_op(4'd15, 4'd15, "d15_15");

        // start re-pulsed with other operands in cycle 2 of RUN is ignored
        launch(4'd12, 4'd5, "d12_5");
        step();
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd3;
        step();
        start = 1'b0;
        wait_done(4'd12, 4'd5, 3, "d12_5");

        // back-to-back: start held in the DONE cycle is accepted
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd3;
        step();
        start = 1'b0;
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.done", 32'(done), 32'd0);
        chk("b2b.hold_q", 32'(quotient), 32'd2);
        chk("b2b.hold_r", 32'(remainder), 32'd2);
        wait_done(4'd9, 4'd3, 1, "d9_3");
        idle_after("d9_3");

        // reset in cycle 2 of a run discards the partial result
        launch(4'd14, 4'd3, "d14_3a");
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.q", 32'(quotient), 32'd0);
        chk("midrst.r", 32'(remainder), 32'd0);
        chk("midrst.dbz", 32'(div_by_zero), 32'd0);
        begin
            int nd;
            nd = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (done) nd++;
            end
            chk("midrst.no_done", 32'(nd), 32'd0);
        end
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;
        full_op(4'd14, 4'd3, "d14_3b");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                full_op(W'(a), W'(b), $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int gap;
            ra  = W'($urandom);
            rb  = W'($urandom);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
            full_op(ra, rb, $sformatf("rand%0d_%0d_%0d", i, ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
